// File: rtl/fcbt_pkg.sv
// Shared FCBT accumulator constants and the group-streamer state type.
package fcbt_pkg;
   localparam int FCBT_WIDTH      = 32;
   localparam int FCBT_MAX_INPUTS = 32768;
   localparam int FCBT_OBUF_SIZE  = 100;

   typedef enum logic {IDLE, STREAM} fcbt_stream_state_t;
endpackage

// File: rtl/fcbt_credit_counter.sv
// Up/down saturating credit counter: simultaneous inc/dec cancel, full flag,
// registered underflow pulse when a decrement arrives at zero.
module fcbt_credit_counter
   import fcbt_pkg::*;
#(
   parameter int MAX = FCBT_OBUF_SIZE,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          underflow
);

   assign full = (count == CW'(MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         underflow <= dec && !inc && (count == '0);
         case ({inc, dec})
            2'b10:   if (!full) count <= count + CW'(1);
            2'b01:   if (count != '0) count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fcbt_group_streamer.sv
// Transmit side of the FCBT accumulator input protocol: turns a group command
// plus a value stream into valid_in/ip/end_of_group beats, with result credit tracking.
module fcbt_group_streamer
   import fcbt_pkg::*;
#(
   parameter int WIDTH           = FCBT_WIDTH,
   parameter int MAX_INPUTS      = FCBT_MAX_INPUTS,
   parameter int MAX_OUTSTANDING = FCBT_OBUF_SIZE,
   parameter int LEN_W           = $clog2(MAX_INPUTS + 1),
   parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready,
   output logic             valid_in,
   output logic             end_of_group,
   output logic [WIDTH-1:0] ip,
   input  logic             valid_out,
   output logic [OUT_W-1:0] outstanding,
   output logic             busy,
   output logic             err_len,
   output logic             err_spurious
);

   fcbt_stream_state_t state;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt;
   logic               credit_full;
   logic               eog_emit;
   logic               credit_block;
   logic               cmd_fire;
   logic               data_fire;
   logic               len_ok;
   logic               last_beat;

   assign eog_emit = valid_in && end_of_group;
   // The group closing this cycle is not yet in the counter; reserve its slot so
   // a command accepted now cannot push the result buffer past its depth.
   assign credit_block = credit_full ||
                         (eog_emit && (outstanding == OUT_W'(MAX_OUTSTANDING - 1)));

   assign cmd_ready  = !rst && (state == IDLE) && !credit_block;
   assign data_ready = (state == STREAM) && ready;
   assign busy       = (state == STREAM);

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign data_fire = data_valid && data_ready;
   assign len_ok    = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_INPUTS));
   assign last_beat = ((cnt + LEN_W'(1)) == len_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         len_q        <= '0;
         cnt          <= '0;
         valid_in     <= 1'b0;
         end_of_group <= 1'b0;
         ip           <= '0;
         err_len      <= 1'b0;
      end else begin
         valid_in     <= 1'b0;
         end_of_group <= 1'b0;
         err_len      <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  if (len_ok) begin
                     len_q <= cmd_len;
                     cnt   <= '0;
                     state <= STREAM;
                  end else begin
                     err_len <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (data_fire) begin
                  valid_in <= 1'b1;
                  ip       <= data_in;
                  cnt      <= cnt + LEN_W'(1);
                  if (last_beat) begin
                     end_of_group <= 1'b1;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fcbt_credit_counter #(
      .MAX (MAX_OUTSTANDING),
      .CW  (OUT_W)
   ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .inc       (eog_emit),
      .dec       (valid_out),
      .count     (outstanding),
      .full      (credit_full),
      .underflow (err_spurious)
   );

endmodule

// File: tb/tb_fcbt_group_streamer.sv
// Directed + randomized bench for fcbt_group_streamer against a queue-based beat model.
module tb_fcbt_group_streamer;
   localparam int WIDTH   = 32;
   localparam int MAX_IN  = 20;
   localparam int MAX_OUT = 2;
   localparam int LEN_W   = $clog2(MAX_IN + 1);
   localparam int OUT_W   = $clog2(MAX_OUT + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             data_valid;
   logic             data_ready;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             valid_in;
   logic             end_of_group;
   logic [WIDTH-1:0] ip;
   logic             valid_out;
   logic [OUT_W-1:0] outstanding;
   logic             busy;
   logic             err_len;
   logic             err_spurious;

   typedef struct {
      logic [WIDTH-1:0] val;
      logic             eog;
      int               cyc;
   } beat_t;

   beat_t            obs_q[$];
   beat_t            exp_q[$];
   bit               pat_q[$];
   logic [WIDTH-1:0] fixed_q[$];

   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   bad_beats = 0;
   int   exp_out   = 0;
   logic prev_ready = 1'b0;

   fcbt_group_streamer #(
      .WIDTH           (WIDTH),
      .MAX_INPUTS      (MAX_IN),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_len      (cmd_len),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .data_in      (data_in),
      .ready        (ready),
      .valid_in     (valid_in),
      .end_of_group (end_of_group),
      .ip           (ip),
      .valid_out    (valid_out),
      .outstanding  (outstanding),
      .busy         (busy),
      .err_len      (err_len),
      .err_spurious (err_spurious)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Beat monitor: a beat may only appear when ready was high the cycle before.
   always @(negedge clk) begin
      if (valid_in) begin
         obs_q.push_back('{ip, end_of_group, cyc});
         if (!prev_ready) bad_beats <= bad_beats + 1;
      end
      prev_ready <= ready && !rst;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_beats(input string tag);
      int n;
      check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_val"}, 64'(obs_q[i].val), 64'(exp_q[i].val));
         check({tag, "_eog"}, 64'(obs_q[i].eog), 64'(exp_q[i].eog));
         check({tag, "_cyc"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic run_group(input string tag, input int len, input bit rnd, input bit vo_on_eog);
      int               guard;
      bit               done;
      logic [WIDTH-1:0] v;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
      #1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         tick();
         guard++;
      end
      check({tag, "_cmd_wait"}, 64'(guard < 50), 64'd1);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         v     = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom;
         done  = 1'b0;
         guard = 0;
         while (!done && guard < 200) begin
            ready      = (pat_q.size() != 0) ? pat_q.pop_front()
                                             : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            data_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_in    = v;
            #1;
            if (data_valid && data_ready) begin
               done = 1'b1;
               exp_q.push_back('{v, (i == len - 1), cyc + 1});
            end
            tick();
            guard++;
         end
         check({tag, "_beat_wait"}, 64'(done), 64'd1);
      end
      data_valid = 1'b0;
      ready      = 1'b1;
      exp_out++;
      if (vo_on_eog) begin
         check({tag, "_eog_now"}, 64'(valid_in && end_of_group), 64'd1);
         valid_out = 1'b1;
         tick();
         valid_out = 1'b0;
         exp_out--;
      end
      tick();
      compare_beats(tag);
      check({tag, "_outstanding"}, 64'(outstanding), 64'(exp_out));
   endtask

   task automatic pulse_vo();
      valid_out = 1'b1;
      tick();
      valid_out = 1'b0;
      if (exp_out > 0) begin
         exp_out--;
         check("vo_no_spurious", 64'(err_spurious), 64'd0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b1;
      cmd_len    = LEN_W'(3);
      data_valid = 1'b0;
      data_in    = '0;
      ready      = 1'b0;
      valid_out  = 1'b0;

      // reset held with a command pending
      repeat (5) begin
         tick();
         check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
         check("rst_valid_in", 64'(valid_in), 64'd0);
      end
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_data_ready", 64'(data_ready), 64'd0);
      check("rst_eog", 64'(end_of_group), 64'd0);
      check("rst_ip", 64'(ip), 64'd0);
      check("rst_err_len", 64'(err_len), 64'd0);
      check("rst_err_spur", 64'(err_spurious), 64'd0);
      cmd_valid = 1'b0;
      rst       = 1'b0;
      #1;
      check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();

      // three floats back to back
      fixed_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
      run_group("g3", 3, 1'b0, 1'b0);
      pulse_vo();
      check("g3_drain", 64'(outstanding), 64'd0);

      // ready toggling mid-group
      pat_q = '{1, 0, 0, 1, 1, 0, 1, 1};
      run_group("g5", 5, 1'b0, 1'b0);
      check("g5_no_beat_when_not_ready", 64'(bad_beats), 64'd0);
      pulse_vo();

      // credit limit blocks the third command
      run_group("full_a", 1, 1'b0, 1'b0);
      run_group("full_b", 1, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(1);
      repeat (6) begin
         tick();
         check("full_stall", 64'(cmd_ready), 64'd0);
      end
      check("full_busy", 64'(busy), 64'd0);
      valid_out = 1'b1;
      tick();
      valid_out = 1'b0;
      exp_out--;
      check("full_release", 64'(cmd_ready), 64'd1);
      run_group("full_c", 1, 1'b0, 1'b0);
      pulse_vo();
      pulse_vo();

      // eog and valid_out together, then a spurious result strobe
      run_group("both_a", 2, 1'b0, 1'b0);
      run_group("both_b", 1, 1'b0, 1'b1);
      check("both_hold", 64'(outstanding), 64'd1);
      pulse_vo();
      valid_out = 1'b1;
      tick();
      valid_out = 1'b0;
      check("spur_pulse", 64'(err_spurious), 64'd1);
      check("spur_zero", 64'(outstanding), 64'd0);
      tick();
      check("spur_clear", 64'(err_spurious), 64'd0);

      // illegal lengths, then the largest legal one
      for (int k = 0; k < 2; k++) begin
         cmd_valid = 1'b1;
         cmd_len   = (k == 0) ? LEN_W'(0) : LEN_W'(MAX_IN + 1);
         tick();
         cmd_valid = 1'b0;
         check("badlen_pulse", 64'(err_len), 64'd1);
         check("badlen_idle", 64'(busy), 64'd0);
         tick();
         check("badlen_clear", 64'(err_len), 64'd0);
         tick();
         check("badlen_no_beats", 64'(obs_q.size()), 64'd0);
      end
      run_group("gmax", MAX_IN, 1'b1, 1'b0);
      pulse_vo();

      // async reset after two of four beats
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(4);
      #1;
      check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid  = 1'b0;
      ready      = 1'b1;
      data_valid = 1'b1;
      data_in    = $urandom;
      tick();
      data_in = $urandom;
      tick();
      data_valid = 1'b0;
      #1;
      check("abort_beat2", 64'(valid_in), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_valid_in", 64'(valid_in), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      tick();
      rst     = 1'b0;
      exp_out = 0;
      obs_q.delete();
      exp_q.delete();
      tick();
      check("abort_outstanding", 64'(outstanding), 64'd0);

      // randomized groups with random ready/valid and result returns
      for (int g = 0; g < 10; g++) begin
         run_group("rnd", int'($urandom_range(1, MAX_IN)), 1'b1, 1'b0);
         if (exp_out == MAX_OUT || $urandom_range(0, 1) == 1) pulse_vo();
      end
      check("final_no_stray_beats", 64'(bad_beats), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
